fir_mac_filter: RTL and testbench
=================================

FIR_MAC_FILTER -- requirements
Module: fir_mac_filter

Interface
REQ-001 Parameter DATA_W, default 8, signed input sample width.
REQ-002 Parameter COEF_W, default 8, signed coefficient width.
REQ-003 Parameter TAPS, default 4, number of taps; legal range 2..64.
REQ-004 Parameter OUT_W, default 16, signed output width; legal range is less than or equal to ACC_W.
REQ-005 Port clk, input, 1, the single clock; all logic is on its rising edge.
REQ-006 Port reset_n, input, 1, asynchronous active-low reset.
REQ-007 Port in_valid / in_ready / in_data, in/out/in, 1/1/DATA_W, signed sample handshake.
REQ-008 Port out_valid / out_ready / out_data, out/in/out, 1/1/OUT_W, signed result handshake.
REQ-009 Port coef_we / coef_addr / coef_data, in/in/in, 1/clog2(TAPS)/COEF_W, coefficient write port.
REQ-010 Port busy, output, 1, high in any state other than IDLE.

Function
REQ-011 The block SHALL compute y[n] = sum over k=0..TAPS-1 of h[k]*x[n-k] using one time-shared signed multiplier and accumulator.
REQ-012 The accumulator width SHALL be ACC_W = DATA_W+COEF_W+clog2(TAPS), with full sign extension, so the accumulation never overflows.
REQ-013 The FSM SHALL have three states, IDLE, MAC and OUT, with these transitions: IDLE->MAC on in_valid&&in_ready; MAC->OUT after TAPS MAC cycles; OUT->IDLE on out_valid&&out_ready.
REQ-014 in_ready SHALL be 1 only in IDLE.
REQ-015 On acceptance, the delay line SHALL shift (x[k]<=x[k-1], x[0]<=in_data) and the accumulator SHALL clear.
REQ-016 In MAC, tap index k SHALL run 0..TAPS-1, one product h[k]*x[k] added per cycle.
REQ-017 Latency: accept at cycle 0, out_valid high at cycle TAPS+1; maximum throughput is one sample per TAPS+2 cycles.
REQ-018 out_valid SHALL be high only in OUT.
REQ-019 out_data SHALL be held stable while out_valid=1 and out_ready=0, for unlimited backpressure.
REQ-020 A coefficient write SHALL take effect only when coef_we=1 in IDLE with no simultaneous sample acceptance.
REQ-021 When a coefficient write coincides with in_valid&&in_ready, the write SHALL be dropped and the sample accepted.
REQ-022 coef_we outside IDLE SHALL be ignored, with no change to h[].
REQ-023 coef_addr >= TAPS SHALL be ignored.
REQ-024 Output reduction from ACC_W to OUT_W SHALL follow REQ-030/REQ-031.

Reset
REQ-025 reset_n=0 SHALL asynchronously force state to IDLE, out_valid=0, out_data=0, busy=0, in_ready=0 while asserted, x[]=0, and accumulator=0.
REQ-026 Reset SHALL set coefficient h[k] = k+1 (i.e. 1,2,3,4 at defaults).
REQ-027 in_ready SHALL rise in the first clk cycle after reset_n deasserts.
REQ-028 A reset mid-MAC or mid-OUT SHALL abort the sample; no partial result is ever presented.

Configuration
REQ-029 The macro FIR_SAT_EN SHALL select the output reduction mode.
REQ-030 With FIR_SAT_EN defined, out_data SHALL be the accumulator clamped to [-(2^(OUT_W-1)), 2^(OUT_W-1)-1].
REQ-031 Without FIR_SAT_EN, out_data SHALL be accumulator[OUT_W-1:0] (two's-complement wrap), with no clamp logic instantiated.

Structure
REQ-032 A shared package fir_pkg SHALL hold the state enum (IDLE/MAC/OUT) and the ACC_W computation function.
REQ-033 Sub-module fir_mac SHALL implement the registered signed multiply-accumulate (clear, enable, product add); the FSM, delay line and coefficient bank SHALL stay in fir_mac_filter.

Verification
REQ-034 Default coefficients, inputs 5,10,0,4 with out_ready=1 -> out_data 5,20,35,54, each TAPS+1=5 cycles after its acceptance.
REQ-035 Write h[0..3]=127, inputs 127 x4 -> fourth output 32767 with FIR_SAT_EN; -1020 without FIR_SAT_EN.
REQ-036 Hold out_ready=0 for 10 cycles in OUT -> out_valid stays 1, out_data stays constant, in_ready stays 0; release -> IDLE next cycle.
REQ-037 Pulse coef_we with coef_addr=0, coef_data=-1 during MAC -> h[0] unchanged, as shown by the next output matching the default-coefficient model.
REQ-038 Assert reset_n=0 at MAC cycle 2 -> out_valid never asserts for that sample; after release, input 5 -> output 5, proving the delay line cleared.
REQ-039 Random in_valid/out_ready over 1000 samples with random coefficient writes in IDLE -> all outputs match a golden model and no sample is lost or duplicated.

Source files
------------

// File: rtl/fir_pkg.sv
// Shared FSM state type and accumulator sizing for the FIR MAC filter.
// Declarations only: no logic, no latency.
// No flow control at package level.
package fir_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MAC  = 2'd1,
        OUT  = 2'd2
    } fir_state_t;

    // Wide enough that TAPS full-scale products can be summed without overflow.
    function automatic int acc_width(input int data_w, input int coef_w, input int taps);
        return data_w + coef_w + $clog2(taps);
    endfunction

endpackage

// File: rtl/fir_mac_filter_if.sv
// Sample, result and coefficient-write signals of the FIR MAC filter.
// Wiring only: no latency.
// Sample and result sides use valid/ready; coefficient writes are fire-and-forget.
interface fir_mac_filter_if #(
    parameter int DATA_W = 8,
    parameter int COEF_W = 8,
    parameter int TAPS   = 4,
    parameter int OUT_W  = 16
);
    logic                        in_valid;
    logic                        in_ready;
    logic signed [DATA_W-1:0]    in_data;
    logic                        out_valid;
    logic                        out_ready;
    logic signed [OUT_W-1:0]     out_data;
    logic                        coef_we;
    logic [$clog2(TAPS)-1:0]     coef_addr;
    logic signed [COEF_W-1:0]    coef_data;

    modport master (
        output in_valid, in_data, out_ready, coef_we, coef_addr, coef_data,
        input  in_ready, out_valid, out_data
    );

    modport slave (
        input  in_valid, in_data, out_ready, coef_we, coef_addr, coef_data,
        output in_ready, out_valid, out_data
    );
endinterface

// File: rtl/fir_mac.sv
// Registered signed multiply-accumulate: acc <= 0 on clr, acc += sample*coef on en.
// Latency: product visible in acc one cycle after en.
// No backpressure; the caller sequences clr/en.
module fir_mac
    import fir_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int COEF_W = 8,
    parameter int TAPS   = 4,
    localparam int ACC_W = acc_width(DATA_W, COEF_W, TAPS)
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     clr,
    input  logic                     en,
    input  logic signed [DATA_W-1:0] sample,
    input  logic signed [COEF_W-1:0] coef,
    output logic signed [ACC_W-1:0]  acc
);
    localparam int PROD_W = DATA_W + COEF_W;

    logic signed [PROD_W-1:0] prod;

    assign prod = PROD_W'(sample) * PROD_W'(coef);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            acc <= '0;
        end else if (clr) begin
            acc <= '0;
        end else if (en) begin
            acc <= acc + ACC_W'(prod);
        end
    end

endmodule

// File: rtl/fir_mac_filter.sv
// Time-shared TAPS-tap FIR; output reduction saturates when FIR_SAT_EN is defined, else wraps.
// Latency: accept at cycle 0, out_valid at cycle TAPS+1; one sample per TAPS+2 cycles.
// in_ready only in IDLE; result held indefinitely while out_ready is low.
module fir_mac_filter
    import fir_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int COEF_W = 8,
    parameter int TAPS   = 4,
    parameter int OUT_W  = 16
) (
    input  logic              clk,
    input  logic              reset_n,
    fir_mac_filter_if.slave   bus,
    output logic              busy
);
    localparam int ACC_W   = acc_width(DATA_W, COEF_W, TAPS);
    localparam int AW      = $clog2(TAPS);
    localparam int TAPS_M1 = TAPS - 1;
    localparam logic [AW-1:0] LAST_K   = TAPS_M1[AW-1:0];
    localparam logic [AW:0]   TAPS_LIM = TAPS[AW:0];

    fir_state_t               state;
    logic [AW-1:0]            k;
    logic signed [DATA_W-1:0] x [TAPS];
    logic signed [COEF_W-1:0] h [TAPS];
    logic signed [ACC_W-1:0]  acc;
    logic                     accept;
    logic                     coef_hit;

    assign accept   = bus.in_valid && bus.in_ready;
    // A sample acceptance wins over a coincident coefficient write.
    assign coef_hit = bus.coef_we && (state == IDLE) && !accept
                      && ({1'b0, bus.coef_addr} < TAPS_LIM);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state         <= IDLE;
            k             <= '0;
            bus.in_ready  <= 1'b0;
            bus.out_valid <= 1'b0;
            busy          <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    bus.in_ready <= 1'b1;
                    if (accept) begin
                        state        <= MAC;
                        k            <= '0;
                        bus.in_ready <= 1'b0;
                        busy         <= 1'b1;
                    end
                end
                MAC: begin
                    if (k == LAST_K) begin
                        state         <= OUT;
                        bus.out_valid <= 1'b1;
                    end else begin
                        k <= k + 1'b1;
                    end
                end
                OUT: begin
                    if (bus.out_ready) begin
                        state         <= IDLE;
                        bus.out_valid <= 1'b0;
                        busy          <= 1'b0;
                        bus.in_ready  <= 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < TAPS; i++) begin
                x[i] <= '0;
                h[i] <= COEF_W'(i + 1);
            end
        end else begin
            if (accept) begin
                x[0] <= bus.in_data;
                for (int i = 1; i < TAPS; i++) begin
                    x[i] <= x[i-1];
                end
            end
            if (coef_hit) begin
                h[bus.coef_addr] <= bus.coef_data;
            end
        end
    end

    fir_mac #(
        .DATA_W (DATA_W),
        .COEF_W (COEF_W),
        .TAPS   (TAPS)
    ) u_mac (
        .clk     (clk),
        .reset_n (reset_n),
        .clr     (accept),
        .en      (state == MAC),
        .sample  (x[k]),
        .coef    (h[k]),
        .acc     (acc)
    );

    // acc is frozen outside MAC, so out_data is stable for the whole OUT state.
`ifdef FIR_SAT_EN
    localparam logic signed [ACC_W-1:0] SAT_MAX = {{(ACC_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] SAT_MIN = {{(ACC_W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

    always_comb begin
        bus.out_data = OUT_W'(acc);
        if (acc > SAT_MAX) begin
            bus.out_data = OUT_W'(SAT_MAX);
        end else if (acc < SAT_MIN) begin
            bus.out_data = OUT_W'(SAT_MIN);
        end
    end
`else
    assign bus.out_data = OUT_W'(acc);
`endif

endmodule

// File: tb/tb_fir_mac_filter.sv
// Directed and randomised checks of fir_mac_filter against hand values and a reference model.
module tb_fir_mac_filter;
    localparam int DATA_W = 8;
    localparam int COEF_W = 8;
    localparam int TAPS   = 4;
    localparam int OUT_W  = 16;
    localparam int AW     = $clog2(TAPS);

    logic clk = 1'b0;
    logic reset_n;
    logic busy;

    int tests = 0;
    int fails = 0;
    int h_m [TAPS];
    int x_m [TAPS];
    int last_exp;

    fir_mac_filter_if #(.DATA_W(DATA_W), .COEF_W(COEF_W), .TAPS(TAPS), .OUT_W(OUT_W)) b ();

    fir_mac_filter #(.DATA_W(DATA_W), .COEF_W(COEF_W), .TAPS(TAPS), .OUT_W(OUT_W)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (b),
        .busy    (busy)
    );

    always #5 clk = ~clk;

    function automatic int reduce(input int a);
        int r;
`ifdef FIR_SAT_EN
        r = a;
        if (a > (1 << (OUT_W-1)) - 1) r = (1 << (OUT_W-1)) - 1;
        if (a < -(1 << (OUT_W-1)))    r = -(1 << (OUT_W-1));
`else
        r = a & ((1 << OUT_W) - 1);
        if (r >= (1 << (OUT_W-1))) r = r - (1 << OUT_W);
`endif
        return r;
    endfunction

    function automatic void model_reset();
        for (int i = 0; i < TAPS; i++) begin
            h_m[i] = i + 1;
            x_m[i] = 0;
        end
    endfunction

    function automatic int model_push(input int v);
        int s = 0;
        for (int i = TAPS-1; i > 0; i--) x_m[i] = x_m[i-1];
        x_m[0] = v;
        for (int i = 0; i < TAPS; i++) s += h_m[i] * x_m[i];
        return reduce(s);
    endfunction

    // Present one sample and hold it until accepted; leaves time just after the accepting edge.
    task automatic send(input int v);
        int n = 0;
        @(negedge clk);
        b.in_valid = 1'b1;
        b.in_data  = DATA_W'(v);
        while (b.in_ready !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) begin
            tests++;
            fails++;
            $display("FAIL send_accept: in_ready=%b after 50 cycles, required 1", b.in_ready);
        end
        @(posedge clk);
        #1;
        b.in_valid = 1'b0;
        last_exp = model_push(v);
    endtask

    task automatic wait_valid(output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (b.out_valid !== 1'b1 && n < 50);
        if (b.out_valid !== 1'b1) n = -1;
    endtask

    task automatic write_coef(input int addr, input int data);
        @(negedge clk);
        b.coef_we   = 1'b1;
        b.coef_addr = AW'(addr);
        b.coef_data = COEF_W'(data);
        @(posedge clk);
        #1;
        b.coef_we = 1'b0;
        h_m[addr] = data;
    endtask

    task automatic test_reset();
        reset_n     = 1'b0;
        b.in_valid  = 1'b0;
        b.in_data   = '0;
        b.out_ready = 1'b0;
        b.coef_we   = 1'b0;
        b.coef_addr = '0;
        b.coef_data = '0;
        repeat (3) @(negedge clk);
        tests++;
        if (b.in_ready !== 1'b0 || b.out_valid !== 1'b0 || busy !== 1'b0 || b.out_data !== '0) begin
            fails++;
            $display("FAIL reset_outputs: in_ready=%b out_valid=%b busy=%b out_data=%0d, required 0 0 0 0",
                     b.in_ready, b.out_valid, busy, b.out_data);
        end
        reset_n = 1'b1;
        #1;
        tests++;
        if (b.in_ready !== 1'b0) begin
            fails++;
            $display("FAIL reset_release_ready: in_ready=%b before first edge, required 0", b.in_ready);
        end
        @(negedge clk);
        tests++;
        if (b.in_ready !== 1'b1 || busy !== 1'b0) begin
            fails++;
            $display("FAIL reset_ready_rise: in_ready=%b busy=%b, required 1 0", b.in_ready, busy);
        end
        model_reset();
    endtask

    task automatic test_basic();
        int vin [4] = '{5, 10, 0, 4};
        int vexp[4] = '{5, 20, 35, 54};
        int n;
        b.out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            send(vin[i]);
            wait_valid(n);
            tests++;
            if (n !== TAPS + 1) begin
                fails++;
                $display("FAIL basic_latency[%0d]: %0d cycles, required %0d", i, n, TAPS + 1);
            end
            tests++;
            if (int'(b.out_data) !== vexp[i]) begin
                fails++;
                $display("FAIL basic_data[%0d]: got %0d, required %0d", i, b.out_data, vexp[i]);
            end
            @(posedge clk);
            #1;
            tests++;
            if (b.out_valid !== 1'b0 || b.in_ready !== 1'b1) begin
                fails++;
                $display("FAIL basic_return_idle[%0d]: out_valid=%b in_ready=%b, required 0 1",
                         i, b.out_valid, b.in_ready);
            end
        end
    endtask

    task automatic test_backpressure();
        int n;
        bit bad = 1'b0;
        b.out_ready = 1'b0;
        send(1);
        wait_valid(n);
        tests++;
        if (n !== TAPS + 1 || int'(b.out_data) !== 49) begin
            fails++;
            $display("FAIL bp_first: latency %0d data %0d, required %0d 49", n, b.out_data, TAPS + 1);
        end
        repeat (10) begin
            @(negedge clk);
            if (b.out_valid !== 1'b1 || int'(b.out_data) !== 49 || b.in_ready !== 1'b0) bad = 1'b1;
        end
        tests++;
        if (bad) begin
            fails++;
            $display("FAIL bp_hold: out_valid=%b out_data=%0d in_ready=%b, required 1 49 0",
                     b.out_valid, b.out_data, b.in_ready);
        end
        b.out_ready = 1'b1;
        @(posedge clk);
        #1;
        tests++;
        if (b.out_valid !== 1'b0 || busy !== 1'b0 || b.in_ready !== 1'b1) begin
            fails++;
            $display("FAIL bp_release: out_valid=%b busy=%b in_ready=%b, required 0 0 1",
                     b.out_valid, busy, b.in_ready);
        end
    endtask

    task automatic test_coef_during_mac();
        int n;
        send(2);
        @(negedge clk);
        b.coef_we   = 1'b1;
        b.coef_addr = '0;
        b.coef_data = -8'sd1;
        @(posedge clk);
        #1;
        b.coef_we = 1'b0;
        wait_valid(n);
        tests++;
        if (int'(b.out_data) !== 16) begin
            fails++;
            $display("FAIL coef_in_mac: got %0d, required 16", b.out_data);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_coef_collision();
        int n = 0;
        @(negedge clk);
        while (b.in_ready !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        b.in_valid  = 1'b1;
        b.in_data   = 8'sd3;
        b.coef_we   = 1'b1;
        b.coef_addr = '0;
        b.coef_data = -8'sd1;
        @(posedge clk);
        #1;
        b.in_valid = 1'b0;
        b.coef_we  = 1'b0;
        last_exp = model_push(3);
        tests++;
        if (busy !== 1'b1) begin
            fails++;
            $display("FAIL collision_accept: busy=%b, required 1", busy);
        end
        wait_valid(n);
        tests++;
        if (int'(b.out_data) !== 26) begin
            fails++;
            $display("FAIL collision_coef: got %0d, required 26", b.out_data);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_saturation();
        int n;
        int want4;
`ifdef FIR_SAT_EN
        want4 = 32767;
`else
        want4 = -1020;
`endif
        for (int i = 0; i < TAPS; i++) write_coef(i, 127);
        for (int i = 0; i < 4; i++) begin
            send(127);
            wait_valid(n);
            tests++;
            if (i < 3 && int'(b.out_data) !== last_exp) begin
                fails++;
                $display("FAIL sat_data[%0d]: got %0d, required %0d", i, b.out_data, last_exp);
            end else if (i == 3 && int'(b.out_data) !== want4) begin
                fails++;
                $display("FAIL sat_fourth: got %0d, required %0d", b.out_data, want4);
            end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_reset_mid_mac();
        int n;
        bit seen = 1'b0;
        send(9);
        @(posedge clk);
        #1;
        reset_n = 1'b0;
        #1;
        tests++;
        if (b.out_valid !== 1'b0 || busy !== 1'b0 || b.in_ready !== 1'b0 || b.out_data !== '0) begin
            fails++;
            $display("FAIL midmac_reset: out_valid=%b busy=%b in_ready=%b out_data=%0d, required 0 0 0 0",
                     b.out_valid, busy, b.in_ready, b.out_data);
        end
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        repeat (10) begin
            @(negedge clk);
            if (b.out_valid === 1'b1) seen = 1'b1;
        end
        tests++;
        if (seen) begin
            fails++;
            $display("FAIL midmac_no_output: out_valid seen 1 after abort, required 0");
        end
        model_reset();
        send(5);
        wait_valid(n);
        tests++;
        if (n !== TAPS + 1 || int'(b.out_data) !== 5) begin
            fails++;
            $display("FAIL midmac_cleared: latency %0d data %0d, required %0d 5", n, b.out_data, TAPS + 1);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_random();
        int q[$];
        int sent = 0;
        int got = 0;
        int cyc = 0;
        int y;
        bit idle;
        bit busy_bad = 1'b0;
        bit acc_ev;
        bit out_ev;
        while (got < 1000 && cyc < 60000) begin
            @(negedge clk);
            cyc++;
            idle = (q.size() == 0);
            if (busy !== !idle) busy_bad = 1'b1;
            b.in_valid  = (sent < 1000) && ($urandom_range(0, 1) == 1);
            b.in_data   = DATA_W'($urandom_range(0, 255));
            b.out_ready = ($urandom_range(0, 1) == 1);
            b.coef_we   = ($urandom_range(0, 3) == 0);
            b.coef_addr = AW'($urandom_range(0, TAPS-1));
            b.coef_data = COEF_W'($urandom_range(0, 255));
            out_ev = b.out_valid && b.out_ready;
            acc_ev = b.in_valid && b.in_ready;
            if (out_ev) begin
                tests++;
                got++;
                if (q.size() == 0) begin
                    fails++;
                    $display("FAIL random_spurious: output %0d with nothing outstanding", b.out_data);
                end else begin
                    y = q.pop_front();
                    if (int'(b.out_data) !== y) begin
                        fails++;
                        $display("FAIL random_data[%0d]: got %0d, required %0d", got, b.out_data, y);
                    end
                end
            end
            if (acc_ev) begin
                q.push_back(model_push(int'(b.in_data)));
                sent++;
            end else if (idle && b.coef_we) begin
                h_m[int'(b.coef_addr)] = int'(b.coef_data);
            end
        end
        @(negedge clk);
        b.in_valid  = 1'b0;
        b.coef_we   = 1'b0;
        b.out_ready = 1'b1;
        tests++;
        if (got !== 1000 || sent !== 1000 || q.size() !== 0) begin
            fails++;
            $display("FAIL random_count: out %0d in %0d pending %0d, required 1000 1000 0",
                     got, sent, q.size());
        end
        tests++;
        if (busy_bad) begin
            fails++;
            $display("FAIL random_busy: busy disagreed with outstanding-sample state, required agreement");
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_backpressure();
        test_coef_during_mac();
        test_coef_collision();
        test_saturation();
        test_reset_mid_mac();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
